mult_hilo_unit: RTL and testbench
=================================

Name: mult_hilo_unit

Overview:
- Sequential unsigned shift-add multiplier with architectural HI/LO registers.
- Sits directly downstream of the ALU control decoder and consumes its registered 6-bit multiplier control code.
- MULTU starts a multi-cycle multiply. MFHI/MFLO are served by the result mux from this block's hi/lo outputs.
- Runs alongside the ALU and shifter in the execute stage.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH bits split into hi/lo
CODE_MULTU, 6'b011001, control code that starts a multiply

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
ctrl  input  6  registered multiplier control code from ALU control stage
dataA  input  WIDTH  multiplicand
dataB  input  WIDTH  multiplier
hi  output  WIDTH  upper half of last completed product
lo  output  WIDTH  lower half of last completed product
busy  output  1  high while a multiply is iterating
done  output  1  one-cycle pulse when hi/lo update

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: hi=0, lo=0, busy=0, done=0; FSM in IDLE; arm flag set; internal registers cleared.
- FSM states: IDLE, RUN, FINISH.
- IDLE -> RUN:
  - Condition: posedge samples ctrl==CODE_MULTU with arm=1.
  - Loads mcand = zero-extended dataA into a 2*WIDTH register.
  - Loads mplier = dataB; clears acc (2*WIDTH) and iteration counter; clears arm.
- RUN, each cycle:
  - If mplier[0], acc += mcand (mod 2^(2*WIDTH)).
  - mcand <<= 1; mplier >>= 1; counter++.
  - After the WIDTH-th iteration -> FINISH.
- FINISH, one cycle:
  - hi <= acc[2W-1:W]; lo <= acc[W-1:0]; done=1 for this cycle only; -> IDLE.
- busy is high in RUN and FINISH; busy=1 for exactly WIDTH+1 cycles after the start edge.
- Latency: start edge at cycle T; hi/lo/done valid after edge T+WIDTH+1.
- Re-arm:
  - arm is set when ctrl is sampled != CODE_MULTU.
  - ctrl held at MULTU across completion does not restart; ctrl must leave MULTU for at least one cycle first.
- ctrl==CODE_MULTU while busy: ignored. Operands stay as captured at start, and dataA/dataB changes during RUN have no effect.
- ctrl changing to any other code during RUN: no effect; the multiply completes.
- hi/lo hold the previous product throughout RUN. MFHI/MFLO issued while busy return stale values (the pipeline stalls on busy; not this block's job).
- All other ctrl codes (ALU/shift/MFHI/MFLO): no state change other than arm.
- Overflow: impossible; the full 2*WIDTH product is kept.
- rst_n asserted mid-RUN: immediate abort to reset values. hi/lo are cleared, not preserved.

Optional Feature:
- Macro: MULT_EARLY_EXIT_EN.
- Defined: in RUN, after an iteration leaves mplier==0 (including a start with dataB==0, after the first iteration), go directly to FINISH.
  - busy length becomes (index of highest set bit of dataB + 1) + 1 cycles, with a minimum of 2.
  - Result is identical to the full iteration.
- Undefined: always exactly WIDTH iterations, fixed latency.

Test Plan:
- Basic multiply: reset, then dataA=3, dataB=5, ctrl=MULTU for 1 cycle -> busy 33 cycles; done pulse at T+33; hi=0, lo=15.
- Max operands: dataA=dataB=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then ctrl=MFLO while idle -> lo stays 0x00000001.
- Held MULTU: ctrl held MULTU for 80 cycles -> exactly one done pulse. Then ctrl=MFHI 1 cycle, then MULTU with dataA=0x10000, dataB=0x10000 -> second done; hi=1, lo=0.
- Mid-run stimulus: during RUN of 7*6, drive dataA=9, dataB=9 and ctrl=MULTU -> lo=42 after latency; no restart, no extra done.
- Reset mid-run: rst_n low at iteration 10 of 0x1234*0x5678 -> hi=lo=0, busy=0 immediately. After release, 2*2 -> lo=4.
- Early exit: with MULT_EARLY_EXIT_EN, dataA=7, dataB=2 -> busy 3 cycles, lo=14. dataB=0 -> busy 2 cycles, lo=0. Without the macro, both take 33 cycles with the same results.

Source files
------------

// File: rtl/mult_hilo_unit_if.sv
// Execute-stage multiplier bus: control code and operands in, HI/LO and status out.
interface mult_hilo_unit_if #(
  parameter int WIDTH = 32
);
  logic [5:0]       ctrl;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (output ctrl, dataA, dataB, input hi, lo, busy, done);
  modport slave  (input ctrl, dataA, dataB, output hi, lo, busy, done);
endinterface

// File: rtl/mult_hilo_unit.sv
// Sequential unsigned shift-add multiplier feeding architectural HI/LO.
// Define MULT_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are all zero.
module mult_hilo_unit #(
  parameter int         WIDTH      = 32,
  parameter logic [5:0] CODE_MULTU = 6'b011001
) (
  input  logic              clk,
  input  logic              rst_n,
  mult_hilo_unit_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d, arm_q, arm_d;
  logic               last_iter;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    last_iter = 1'b0;
    // Any non-MULTU sample re-arms; a held MULTU never restarts on its own.
    arm_d    = (bus.ctrl != CODE_MULTU) ? 1'b1 : arm_q;

    unique case (state_q)
      IDLE: begin
        if (bus.ctrl == CODE_MULTU && arm_q) begin
          state_d  = RUN;
          mcand_d  = {{WIDTH{1'b0}}, bus.dataA};
          mplier_d = bus.dataB;
          acc_d    = '0;
          cnt_d    = '0;
          arm_d    = 1'b0;
          busy_d   = 1'b1;
        end
      end
      RUN: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
`ifdef MULT_EARLY_EXIT_EN
        last_iter = (cnt_q == CW'(WIDTH - 1)) || (mplier_d == '0);
`else
        last_iter = (cnt_q == CW'(WIDTH - 1));
`endif
        if (last_iter) state_d = FINISH;
      end
      FINISH: begin
        hi_d    = acc_q[2*WIDTH-1:WIDTH];
        lo_d    = acc_q[WIDTH-1:0];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      arm_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      arm_q    <= arm_d;
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_mult_hilo_unit.sv
// Directed bench for mult_hilo_unit: latency, results, re-arm, mid-run stimulus and reset abort.
module tb_mult_hilo_unit;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] ALU   = 6'b100000;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MFLO  = 6'b010010;

`ifdef MULT_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  mult_hilo_unit_if #(.WIDTH(32)) bus ();
  mult_hilo_unit #(.WIDTH(32), .CODE_MULTU(MULTU)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Pulses MULTU for one cycle and measures busy length and done pulses.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         output int busy_cyc, output int done_cnt);
    @(negedge clk);
    bus.ctrl = MULTU; bus.dataA = a; bus.dataB = b;
    @(negedge clk);
    bus.ctrl = ALU;
    busy_cyc = 0; done_cnt = 0;
    while (bus.busy && busy_cyc < 200) begin
      busy_cyc++;
      done_cnt += int'(bus.done);
      @(negedge clk);
    end
    done_cnt += int'(bus.done);
    @(negedge clk);
    done_cnt += int'(bus.done);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; bus.ctrl = ALU; bus.dataA = '0; bus.dataB = '0;
    repeat (3) @(negedge clk);
    tests++; if (bus.hi !== 32'd0)  begin fails++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
    tests++; if (bus.lo !== 32'd0)  begin fails++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int bc, dc;
    run_mul(32'd3, 32'd5, bc, dc);
    tests++; if (bc != (EE ? 4 : 33)) begin fails++; $display("FAIL basic_busy got=%0d exp=%0d", bc, EE ? 4 : 33); end
    tests++; if (dc != 1)             begin fails++; $display("FAIL basic_done got=%0d exp=1", dc); end
    tests++; if (bus.hi !== 32'd0)    begin fails++; $display("FAIL basic_hi got=%h exp=0", bus.hi); end
    tests++; if (bus.lo !== 32'd15)   begin fails++; $display("FAIL basic_lo got=%h exp=f", bus.lo); end
  endtask

  task automatic test_max;
    int bc, dc;
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dc);
    tests++; if (bc != 33)                 begin fails++; $display("FAIL max_busy got=%0d exp=33", bc); end
    tests++; if (bus.hi !== 32'hFFFF_FFFE) begin fails++; $display("FAIL max_hi got=%h exp=fffffffe", bus.hi); end
    tests++; if (bus.lo !== 32'h0000_0001) begin fails++; $display("FAIL max_lo got=%h exp=1", bus.lo); end
    bus.ctrl = MFLO;
    repeat (3) @(negedge clk);
    tests++; if (bus.lo !== 32'h0000_0001) begin fails++; $display("FAIL mflo_lo got=%h exp=1", bus.lo); end
    tests++; if (bus.busy !== 1'b0)        begin fails++; $display("FAIL mflo_busy got=%b exp=0", bus.busy); end
    bus.ctrl = ALU;
  endtask

  task automatic test_held_multu;
    int dc, bc, dc2;
    @(negedge clk);
    bus.ctrl = MULTU; bus.dataA = 32'd4; bus.dataB = 32'd4;
    dc = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      dc += int'(bus.done);
    end
    tests++; if (dc != 1)           begin fails++; $display("FAIL held_done_count got=%0d exp=1", dc); end
    tests++; if (bus.lo !== 32'd16) begin fails++; $display("FAIL held_lo got=%h exp=10", bus.lo); end
    bus.ctrl = MFHI;
    run_mul(32'h1_0000, 32'h1_0000, bc, dc2);
    tests++; if (dc2 != 1)         begin fails++; $display("FAIL rearm_done got=%0d exp=1", dc2); end
    tests++; if (bus.hi !== 32'd1) begin fails++; $display("FAIL rearm_hi got=%h exp=1", bus.hi); end
    tests++; if (bus.lo !== 32'd0) begin fails++; $display("FAIL rearm_lo got=%h exp=0", bus.lo); end
  endtask

  task automatic test_midrun;
    int bc, dc;
    @(negedge clk);
    bus.ctrl = MULTU; bus.dataA = 32'd7; bus.dataB = 32'd6;
    @(negedge clk);
    // First busy cycle: HI/LO still hold the 0x10000*0x10000 product.
    tests++; if (bus.hi !== 32'd1) begin fails++; $display("FAIL stale_hi got=%h exp=1", bus.hi); end
    bus.ctrl = MULTU; bus.dataA = 32'd9; bus.dataB = 32'd9;
    bc = 0; dc = 0;
    for (int i = 0; i < 60; i++) begin
      if (i == 2) bus.ctrl = ALU;
      bc += int'(bus.busy);
      dc += int'(bus.done);
      @(negedge clk);
    end
    tests++; if (bc != (EE ? 4 : 33)) begin fails++; $display("FAIL midrun_busy got=%0d exp=%0d", bc, EE ? 4 : 33); end
    tests++; if (dc != 1)             begin fails++; $display("FAIL midrun_done got=%0d exp=1", dc); end
    tests++; if (bus.lo !== 32'd42)   begin fails++; $display("FAIL midrun_lo got=%h exp=2a", bus.lo); end
    tests++; if (bus.hi !== 32'd0)    begin fails++; $display("FAIL midrun_hi got=%h exp=0", bus.hi); end
  endtask

  task automatic test_reset_midrun;
    int bc, dc;
    @(negedge clk);
    bus.ctrl = MULTU; bus.dataA = 32'h1234; bus.dataB = 32'h5678;
    @(negedge clk);
    bus.ctrl = ALU;
    repeat (10) @(negedge clk);
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL prereset_busy got=%b exp=1", bus.busy); end
    rst_n = 1'b0;
    #1;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
    tests++; if (bus.lo !== 32'd0)  begin fails++; $display("FAIL abort_lo got=%h exp=0", bus.lo); end
    tests++; if (bus.hi !== 32'd0)  begin fails++; $display("FAIL abort_hi got=%h exp=0", bus.hi); end
    @(negedge clk);
    rst_n = 1'b1;
    run_mul(32'd2, 32'd2, bc, dc);
    tests++; if (bus.lo !== 32'd4) begin fails++; $display("FAIL post_reset_lo got=%h exp=4", bus.lo); end
    tests++; if (dc != 1)          begin fails++; $display("FAIL post_reset_done got=%0d exp=1", dc); end
  endtask

  task automatic test_early_exit;
    int bc, dc;
    run_mul(32'd7, 32'd2, bc, dc);
    tests++; if (bc != (EE ? 3 : 33)) begin fails++; $display("FAIL ee_busy_b2 got=%0d exp=%0d", bc, EE ? 3 : 33); end
    tests++; if (bus.lo !== 32'd14)   begin fails++; $display("FAIL ee_lo_b2 got=%h exp=e", bus.lo); end
    run_mul(32'd7, 32'd0, bc, dc);
    tests++; if (bc != (EE ? 2 : 33)) begin fails++; $display("FAIL ee_busy_b0 got=%0d exp=%0d", bc, EE ? 2 : 33); end
    tests++; if (bus.lo !== 32'd0)    begin fails++; $display("FAIL ee_lo_b0 got=%h exp=0", bus.lo); end
    tests++; if (dc != 1)             begin fails++; $display("FAIL ee_done_b0 got=%0d exp=1", dc); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_held_multu();
    test_midrun();
    test_reset_midrun();
    test_early_exit();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
